// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: parametrised N-master bus arbiter.
// Issues a registered one-hot grant to one requesting master. The grant is held
// until the slave pulses done, the owner withdraws its request, or the hold
// watchdog expires. A watchdog revocation raises a one-cycle timeout pulse.
// Fixed priority (index 0 highest) or round-robin selection is chosen by
// RR_MODE. At least one idle cycle always separates two grants.
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 4,   // 2..16
  parameter int IDX_WIDTH   = 2,   // >= clog2(NUM_MASTERS)
  parameter int RR_MODE     = 1,   // 0 = fixed priority, 1 = round-robin
  parameter int TIMEOUT     = 16   // 2..255 cycles of maximum hold
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   done,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_WIDTH-1:0]   grant_idx,
  output logic                   busy,
  output logic                   timeout
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Hold counter is wide enough for the largest legal TIMEOUT (255).
  localparam int                  CNT_W      = 8;
  localparam logic [CNT_W-1:0]    LP_CNT_MAX = CNT_W'(TIMEOUT - 1);

  // Index arithmetic is done one bit wider so base+offset cannot overflow
  // before the wrap-around correction.
  localparam int                  IW1        = IDX_WIDTH + 1;
  localparam logic [IW1-1:0]      LP_NUM     = IW1'(NUM_MASTERS);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_e                   r_state;
  logic [NUM_MASTERS-1:0]   r_grant;
  logic [IDX_WIDTH-1:0]     r_grant_idx;
  logic [CNT_W-1:0]         r_cnt;
  logic [IDX_WIDTH-1:0]     r_ptr;
  logic                     r_timeout;

  // ---------------------------------------------------------------------------
  // Next-state and arbitration wires
  // ---------------------------------------------------------------------------
  state_e                   w_state_nxt;
  logic [NUM_MASTERS-1:0]   w_grant_nxt;
  logic [IDX_WIDTH-1:0]     w_grant_idx_nxt;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic [IDX_WIDTH-1:0]     w_ptr_nxt;
  logic                     w_timeout_nxt;

  logic [IDX_WIDTH-1:0]     w_base;
  logic [2*NUM_MASTERS-1:0] w_req_dbl;
  logic [NUM_MASTERS-1:0]   w_req_rot;
  logic [IW1-1:0]           w_offset;
  logic [IW1-1:0]           w_sum;
  logic [IDX_WIDTH-1:0]     w_winner;
  logic [IW1-1:0]           w_winner_p1;
  logic [IDX_WIDTH-1:0]     w_ptr_adv;
  logic [NUM_MASTERS-1:0]   w_winner_onehot;

  logic                     w_any_req;
  logic                     w_owner_req;
  logic                     w_wdog;
  logic                     w_release;

  // ---------------------------------------------------------------------------
  // Winner selection: rotate the request vector so the search base sits at
  // bit 0, take the lowest set bit, then rotate the result back.
  // Fixed mode simply uses a base of zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_base    = (RR_MODE != 0) ? r_ptr : '0;
    w_req_dbl = {req, req};
    w_req_rot = NUM_MASTERS'(w_req_dbl >> w_base);

    // Scan downward so the lowest set bit is the last one written.
    w_offset = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (w_req_rot[i]) begin
        w_offset = IW1'(i);
      end
    end

    w_sum    = {1'b0, w_base} + w_offset;
    w_winner = (w_sum >= LP_NUM) ? IDX_WIDTH'(w_sum - LP_NUM)
                                 : IDX_WIDTH'(w_sum);

    // Round-robin pointer moves to the master just after the winner.
    w_winner_p1 = {1'b0, w_winner} + IW1'(1);
    w_ptr_adv   = (w_winner_p1 == LP_NUM) ? '0 : IDX_WIDTH'(w_winner_p1);

    w_winner_onehot = NUM_MASTERS'(1) << w_winner;
  end

  // ---------------------------------------------------------------------------
  // Release conditions for the current owner.
  // The grant is one-hot, so masking req with it yields req[grant_idx].
  // ---------------------------------------------------------------------------
  always_comb begin
    w_any_req   = |req;
    w_owner_req = |(req & r_grant);
    w_wdog      = (r_cnt == LP_CNT_MAX);
    w_release   = done | ~w_owner_req | w_wdog;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_grant_idx_nxt = r_grant_idx;
    w_cnt_nxt       = r_cnt;
    w_ptr_nxt       = r_ptr;
    w_timeout_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        // done while idle has no meaning and is ignored.
        if (w_any_req) begin
          w_state_nxt     = ST_BUSY;
          w_grant_nxt     = w_winner_onehot;
          w_grant_idx_nxt = w_winner;
          w_cnt_nxt       = '0;
          if (RR_MODE != 0) begin
            w_ptr_nxt = w_ptr_adv;
          end
        end
      end

      ST_BUSY: begin
        // Saturating hold counter; requests from other masters are ignored.
        if (!w_wdog) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
        if (w_release) begin
          // Always fall back to IDLE, which guarantees the dead cycle even
          // when the same master re-requests. grant_idx keeps its last value.
          w_state_nxt   = ST_IDLE;
          w_grant_nxt   = '0;
          // Watchdog pulse only when nothing else would have ended the grant;
          // a coincident done takes precedence.
          w_timeout_nxt = w_wdog & ~done & w_owner_req;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register; asynchronous reset drops the grant immediately.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_timeout   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge, independent of statement order.
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ptr       <= w_ptr_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from registers.
  // ---------------------------------------------------------------------------
  assign grant     = r_grant;
  assign grant_idx = r_grant_idx;
  assign busy      = (r_state == ST_BUSY);
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: directed bench for bus_arbiter_n.
// Two instances share clock and reset: u_fix (fixed priority) and u_rr
// (round-robin), both with four masters and a 16-cycle watchdog.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_arbiter_n;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;

  logic [N-1:0]  req_f, req_r;
  logic          done_f, done_r;
  logic [N-1:0]  grant_f, grant_r;
  logic [IW-1:0] idx_f, idx_r;
  logic          busy_f, busy_r;
  logic          timeout_f, timeout_r;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter_n #(.NUM_MASTERS(N), .IDX_WIDTH(IW), .RR_MODE(0), .TIMEOUT(16)) u_fix (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_f),
    .done      (done_f),
    .grant     (grant_f),
    .grant_idx (idx_f),
    .busy      (busy_f),
    .timeout   (timeout_f)
  );

  bus_arbiter_n #(.NUM_MASTERS(N), .IDX_WIDTH(IW), .RR_MODE(1), .TIMEOUT(16)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_r),
    .done      (done_r),
    .grant     (grant_r),
    .grant_idx (idx_r),
    .busy      (busy_r),
    .timeout   (timeout_r)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Grant must never be multi-hot on either instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_checks++;
      if ($countones(grant_f) > 1 || $countones(grant_r) > 1) begin
        n_errors++;
        $display("FAIL onehot: grant_f=%b grant_r=%b expected at most one bit set", grant_f, grant_r);
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    req_f  = '0;
    req_r  = '0;
    done_f = 1'b0;
    done_r = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reset values, reset holding off a pending request, then one transfer.
  task automatic test_reset();
    rst_n  = 1'b0;
    req_f  = 4'b0100;
    req_r  = 4'b0100;
    done_f = 1'b0;
    done_r = 1'b0;
    tick();
    n_checks++;
    if (grant_r !== 4'b0000 || busy_r !== 1'b0 || timeout_r !== 1'b0 || idx_r !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_state: grant=%b busy=%b timeout=%b idx=%0d expected 0000 0 0 0",
               grant_r, busy_r, timeout_r, idx_r);
    end
    tick();
    n_checks++;
    if (grant_f !== 4'b0000 || busy_f !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hold: grant=%b busy=%b expected 0000 0", grant_f, busy_f);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (grant_r !== 4'b0100 || idx_r !== 2'd2 || busy_r !== 1'b1) begin
      n_errors++;
      $display("FAIL first_grant_rr: grant=%b idx=%0d busy=%b expected 0100 2 1", grant_r, idx_r, busy_r);
    end
    n_checks++;
    if (grant_f !== 4'b0100 || idx_f !== 2'd2) begin
      n_errors++;
      $display("FAIL first_grant_fix: grant=%b idx=%0d expected 0100 2", grant_f, idx_f);
    end
    done_f = 1'b1;
    done_r = 1'b1;
    tick();
    done_f = 1'b0;
    done_r = 1'b0;
    req_f  = '0;
    req_r  = '0;
    n_checks++;
    if (grant_r !== 4'b0000 || busy_r !== 1'b0 || timeout_r !== 1'b0 || idx_r !== 2'd2) begin
      n_errors++;
      $display("FAIL done_release: grant=%b busy=%b timeout=%b idx=%0d expected 0000 0 0 2",
               grant_r, busy_r, timeout_r, idx_r);
    end
    tick();
  endtask

  // Fixed priority: master 1 always beats master 3.
  task automatic test_fixed_priority();
    apply_reset();
    req_f = 4'b1010;
    for (int r = 0; r < 3; r++) begin
      tick();
      n_checks++;
      if (grant_f !== 4'b0010 || idx_f !== 2'd1) begin
        n_errors++;
        $display("FAIL fix_grant round %0d: grant=%b idx=%0d expected 0010 1", r, grant_f, idx_f);
      end
      tick();
      tick();
      n_checks++;
      if (grant_f !== 4'b0010 || busy_f !== 1'b1) begin
        n_errors++;
        $display("FAIL fix_hold round %0d: grant=%b busy=%b expected 0010 1", r, grant_f, busy_f);
      end
      done_f = 1'b1;
      tick();
      done_f = 1'b0;
      n_checks++;
      if (grant_f !== 4'b0000 || timeout_f !== 1'b0) begin
        n_errors++;
        $display("FAIL fix_idle round %0d: grant=%b timeout=%b expected 0000 0", r, grant_f, timeout_f);
      end
    end
    req_f = '0;
    tick();
  endtask

  // Round-robin: all four request, grants rotate 0,1,2,3,0 with idle gaps.
  task automatic test_round_robin();
    logic [IW-1:0] exp_idx [5];
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    apply_reset();
    req_r = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      tick();
      n_checks++;
      if (idx_r !== exp_idx[r] || grant_r !== (4'b0001 << exp_idx[r])) begin
        n_errors++;
        $display("FAIL rr_grant round %0d: grant=%b idx=%0d expected idx %0d", r, grant_r, idx_r, exp_idx[r]);
      end
      tick();
      done_r = 1'b1;
      tick();
      done_r = 1'b0;
      n_checks++;
      if (grant_r !== 4'b0000 || busy_r !== 1'b0) begin
        n_errors++;
        $display("FAIL rr_dead_cycle round %0d: grant=%b busy=%b expected 0000 0", r, grant_r, busy_r);
      end
    end
    req_r = '0;
    tick();
  endtask

  // Watchdog: 16 cycles of grant, one-cycle timeout pulse, re-grant.
  task automatic test_watchdog();
    apply_reset();
    req_f = 4'b0001;
    tick();
    n_checks++;
    if (grant_f !== 4'b0001) begin
      n_errors++;
      $display("FAIL wdog_grant: grant=%b expected 0001", grant_f);
    end
    for (int c = 2; c <= 16; c++) begin
      tick();
      n_checks++;
      if (grant_f !== 4'b0001 || timeout_f !== 1'b0) begin
        n_errors++;
        $display("FAIL wdog_hold cycle %0d: grant=%b timeout=%b expected 0001 0", c, grant_f, timeout_f);
      end
    end
    tick();
    n_checks++;
    if (grant_f !== 4'b0000 || timeout_f !== 1'b1 || busy_f !== 1'b0) begin
      n_errors++;
      $display("FAIL wdog_revoke: grant=%b timeout=%b busy=%b expected 0000 1 0", grant_f, timeout_f, busy_f);
    end
    tick();
    n_checks++;
    if (grant_f !== 4'b0001 || timeout_f !== 1'b0) begin
      n_errors++;
      $display("FAIL wdog_regrant: grant=%b timeout=%b expected 0001 0", grant_f, timeout_f);
    end
    req_f = '0;
    tick();
    n_checks++;
    if (grant_f !== 4'b0000 || timeout_f !== 1'b0) begin
      n_errors++;
      $display("FAIL wdog_withdraw: grant=%b timeout=%b expected 0000 0", grant_f, timeout_f);
    end
    tick();
  endtask

  // done on the 16th grant cycle wins over the watchdog.
  task automatic test_done_at_timeout();
    apply_reset();
    req_f = 4'b0001;
    tick();
    repeat (15) tick();
    done_f = 1'b1;
    tick();
    done_f = 1'b0;
    req_f  = '0;
    n_checks++;
    if (grant_f !== 4'b0000 || timeout_f !== 1'b0) begin
      n_errors++;
      $display("FAIL done_vs_wdog: grant=%b timeout=%b expected 0000 0", grant_f, timeout_f);
    end
    tick();
    n_checks++;
    if (timeout_f !== 1'b0 || busy_f !== 1'b0) begin
      n_errors++;
      $display("FAIL done_vs_wdog_after: timeout=%b busy=%b expected 0 0", timeout_f, busy_f);
    end
  endtask

  // Owner withdrawing its request ends the grant next cycle.
  task automatic test_owner_drop();
    apply_reset();
    req_f = 4'b0001;
    tick();
    tick();
    req_f = '0;
    tick();
    n_checks++;
    if (grant_f !== 4'b0000 || busy_f !== 1'b0 || timeout_f !== 1'b0) begin
      n_errors++;
      $display("FAIL owner_drop: grant=%b busy=%b timeout=%b expected 0000 0 0", grant_f, busy_f, timeout_f);
    end
    tick();
  endtask

  // A non-owner request during a grant waits for the idle cycle.
  task automatic test_back_to_back();
    apply_reset();
    req_f = 4'b0010;
    tick();
    req_f = 4'b0110;
    tick();
    n_checks++;
    if (grant_f !== 4'b0010 || idx_f !== 2'd1) begin
      n_errors++;
      $display("FAIL b2b_ignore: grant=%b idx=%0d expected 0010 1", grant_f, idx_f);
    end
    done_f = 1'b1;
    tick();
    done_f = 1'b0;
    req_f  = 4'b0100;
    n_checks++;
    if (grant_f !== 4'b0000) begin
      n_errors++;
      $display("FAIL b2b_idle: grant=%b expected 0000", grant_f);
    end
    tick();
    n_checks++;
    if (grant_f !== 4'b0100 || idx_f !== 2'd2) begin
      n_errors++;
      $display("FAIL b2b_next: grant=%b idx=%0d expected 0100 2", grant_f, idx_f);
    end
    req_f = '0;
    tick();
    tick();
  endtask

  // Reset between edges drops the grant at once and clears the RR pointer.
  task automatic test_async_reset();
    apply_reset();
    req_r = 4'b1000;
    tick();
    tick();
    n_checks++;
    if (grant_r !== 4'b1000) begin
      n_errors++;
      $display("FAIL areset_pre: grant=%b expected 1000", grant_r);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant_r !== 4'b0000 || busy_r !== 1'b0) begin
      n_errors++;
      $display("FAIL areset_drop: grant=%b busy=%b expected 0000 0", grant_r, busy_r);
    end
    req_r = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (grant_r !== 4'b0001 || idx_r !== 2'd0) begin
      n_errors++;
      $display("FAIL areset_first: grant=%b idx=%0d expected 0001 0", grant_r, idx_r);
    end

    // Grant master 2 (pointer moves to 3), then reset mid-grant.
    apply_reset();
    req_r = 4'b0100;
    tick();
    n_checks++;
    if (grant_r !== 4'b0100) begin
      n_errors++;
      $display("FAIL areset_pre2: grant=%b expected 0100", grant_r);
    end
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant_r !== 4'b0000) begin
      n_errors++;
      $display("FAIL areset_drop2: grant=%b expected 0000", grant_r);
    end
    req_r = 4'b1111;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (grant_r !== 4'b0001 || idx_r !== 2'd0) begin
      n_errors++;
      $display("FAIL areset_ptr: grant=%b idx=%0d expected 0001 0", grant_r, idx_r);
    end
    req_r = '0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_watchdog();
    test_done_at_timeout();
    test_owner_drop();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_n.md
Name: bus_arbiter_n

Overview:
Parametrised N-master bus arbiter. It is the successor to the fixed two-party arbiter in the master/slave/arbiter system. It accepts per-master requests and issues a one-hot registered grant held until the slave signals completion, the master withdraws, or a watchdog timeout expires. It supports fixed-priority and round-robin modes, and sits between the master instances and the shared slave.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
IDX_WIDTH, 2, width of grant index; must be >= clog2(NUM_MASTERS)
RR_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round-robin
TIMEOUT, 16, maximum cycles a grant may be held (2..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_MASTERS  per-master request, level, held until grant and transfer end
done  input  1  slave completion pulse for current transfer
grant  output  NUM_MASTERS  one-hot registered grant, all-zero when idle
grant_idx  output  IDX_WIDTH  index of granted master, valid while busy
busy  output  1  high while any grant asserted
timeout  output  1  one-cycle pulse when a grant is revoked by watchdog

Behaviour:
- Reset, asynchronous on rst_n low:
  - grant=0, grant_idx=0, busy=0, timeout=0.
  - Hold counter=0, round-robin pointer=0, state=IDLE.
  - Deassertion is recognised on the next clk edge.
- State machine has two states: IDLE and BUSY.
- IDLE:
  - If req is nonzero, select a winner combinationally.
  - On the next edge: grant=onehot(winner), grant_idx=winner, busy=1, counter=0, state=BUSY.
  - Latency from req rising to grant rising is 1 clock.
- Winner selection:
  - Fixed mode: lowest set index.
  - RR mode: first set index searching upward from pointer, wrapping NUM_MASTERS-1 -> 0.
  - On each grant the pointer becomes (winner+1) mod NUM_MASTERS. The pointer is unused in fixed mode.
- BUSY:
  - Counter increments every cycle and saturates at TIMEOUT-1.
  - Release occurs when any of the following holds: done=1; req[grant_idx]=0; counter==TIMEOUT-1.
  - On release, the next edge sets grant=0, busy=0, state=IDLE. grant_idx holds its last value.
- Timeout:
  - Pulses 1 for exactly the cycle after release, only when release was caused by the watchdog and done=0 and req[grant_idx]=1.
  - If done coincides with counter==TIMEOUT-1, done wins and timeout stays 0.
- Dead cycle: at least one idle cycle (grant=0) always separates consecutive grants, including same-master re-grant. Back-to-back grants to different masters are therefore 1 idle cycle apart.
- Requests from non-owners during BUSY are ignored; they are arbitrated in the next IDLE cycle.
- done while IDLE is ignored.
- req bits at index >= NUM_MASTERS do not exist.
- The grant is never multi-hot. This is checked by assertion in the bench.
- Reset mid-BUSY drops the grant immediately (asynchronously) and returns the pointer to 0.

Test Plan:
- Reset and single request: rst_n low with req=4'b0100 → grant=0, busy=0. After release, the first edge gives grant=4'b0100 and grant_idx=2. done pulse → grant=0 the next cycle, timeout=0.
- Fixed priority (RR_MODE=0): req=4'b1010 held, done pulse 3 cycles after each grant. The sequence is grant 4'b0010 each time; master 3 starves while master 1 requests.
- Round-robin fairness (RR_MODE=1): req=4'b1111 held, done 2 cycles after each grant. The grant sequence is 0,1,2,3,0, with one idle cycle between each.
- Watchdog (TIMEOUT=16): req=4'b0001 held, no done. grant is high for exactly 16 cycles, then grant=0 and timeout=1 for one cycle. Re-grant to master 0 follows after the idle cycle.
- Boundary and simultaneous events:
  - done asserted on the 16th grant cycle → release with timeout=0.
  - Owner drops req mid-grant → grant=0 the next cycle.
  - New req from master 2 during master 1's grant → master 2 is granted after the idle cycle.
- Asynchronous reset mid-transfer: rst_n pulsed low between edges while grant=4'b1000 → grant=0 immediately. After release, req=4'b1111 in RR mode grants master 0 first.
